tm_sequencer: RTL and testbench

TM_SEQUENCER -- requirements
Module: tm_sequencer

---
 rtl/tm_sequencer_if.sv | 31 +++
 rtl/tm_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_tm_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tm_sequencer_if.sv
// tm_sequencer_if: control bus between the button sequencer and the Turing machine core.
// The master side (sequencer) drives clear/write/step and observes the core's halt flag.
interface tm_sequencer_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 6
);
    logic              tm_halted;
    logic              tm_clear;
    logic              tm_wr_en;
    logic [ADDR_W-1:0] tm_wr_addr;
    logic [DATA_W-1:0] tm_wr_data;
    logic              tm_step;

    modport master (
        input  tm_halted,
        output tm_clear,
        output tm_wr_en,
        output tm_wr_addr,
        output tm_wr_data,
        output tm_step
    );

    modport slave (
        output tm_halted,
        input  tm_clear,
        input  tm_wr_en,
        input  tm_wr_addr,
        input  tm_wr_data,
        input  tm_step
    );
endinterface

// File: rtl/tm_sequencer.sv
// tm_sequencer: button-driven tape loader and run controller for a Turing machine core.
// Build macro TM_SEQ_SINGLE_STEP_EN: when defined, RUN advances one step per next_in press.
module tm_sequencer #(
    parameter int DATA_W    = 4,
    parameter int TAPE_LEN  = 64,
    parameter int MAX_STEPS = 1000,
    localparam int ADDR_W   = $clog2(TAPE_LEN),
    localparam int STEP_W   = 10
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              next_in,
    input  logic              done_in,
    tm_sequencer_if.master    tm,
    output logic              busy,
    output logic              compute_done,
    output logic              timeout,
    output logic [STEP_W-1:0] step_count
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_HALT    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    state_t state_r;
    state_t state_next_s;

    logic [2:0]        next_sync_r;
    logic [2:0]        done_sync_r;
    logic [DATA_W-1:0] data_s1_r;
    logic [DATA_W-1:0] data_s2_r;
    logic [1:0]        vld_r;
    logic              next_arm_r;
    logic              done_arm_r;
    logic              next_ev_r;
    logic              done_ev_r;

    logic              tm_clear_r;
    logic              tm_wr_en_r;
    logic [ADDR_W-1:0] tm_wr_addr_r;
    logic [DATA_W-1:0] tm_wr_data_r;
    logic [ADDR_W-1:0] addr_r;
    logic              full_r;
    logic              wr_pend_r;
    logic              done_pend_r;
    logic [STEP_W-1:0] step_count_r;
    logic              busy_r;
    logic              compute_done_r;
    logic              timeout_r;

    logic              clear_s;
    logic              pend_s;
    logic              wr_s;
    logic              capture_s;
    logic              run_entry_s;
    logic              done_pend_s;
    logic              step_en_s;
    logic              tm_step_s;

`ifdef TM_SEQ_SINGLE_STEP_EN
    assign step_en_s = next_ev_r;
`else
    assign step_en_s = 1'b1;
`endif

    // The clear and write strobe cycles are kept free of steps so the three strobes never overlap
    assign tm_step_s = (state_r == ST_RUN) & ~tm.tm_halted & step_en_s & ~tm_clear_r & ~tm_wr_en_r;

    // Pin synchronizers and rising-edge events; an event needs the pin seen low after reset release
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            next_sync_r <= 3'b000;
            done_sync_r <= 3'b000;
            data_s1_r   <= {DATA_W{1'b0}};
            data_s2_r   <= {DATA_W{1'b0}};
            vld_r       <= 2'b00;
            next_arm_r  <= 1'b0;
            done_arm_r  <= 1'b0;
            next_ev_r   <= 1'b0;
            done_ev_r   <= 1'b0;
        end else begin
            next_sync_r <= {next_sync_r[1:0], next_in};
            done_sync_r <= {done_sync_r[1:0], done_in};
            data_s1_r   <= data_in;
            data_s2_r   <= data_s1_r;
            vld_r       <= {vld_r[0], 1'b1};
            next_arm_r  <= next_arm_r | (vld_r[1] & ~next_sync_r[1]);
            done_arm_r  <= done_arm_r | (vld_r[1] & ~done_sync_r[1]);
            next_ev_r   <= next_sync_r[1] & ~next_sync_r[2] & next_arm_r;
            done_ev_r   <= done_sync_r[1] & ~done_sync_r[2] & done_arm_r;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and strobe decisions
    always_comb begin
        state_next_s = state_r;
        clear_s      = 1'b0;
        pend_s       = 1'b0;
        wr_s         = 1'b0;
        capture_s    = 1'b0;
        run_entry_s  = 1'b0;
        done_pend_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (next_ev_r) begin
                    state_next_s = ST_LOAD;
                    clear_s      = 1'b1;
                    pend_s       = 1'b1;
                    capture_s    = 1'b1;
                end else if (done_ev_r) begin
                    state_next_s = ST_RUN;
                    clear_s      = 1'b1;
                    run_entry_s  = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                wr_s      = ~full_r & (wr_pend_r | next_ev_r);
                capture_s = ~full_r & ~wr_pend_r & next_ev_r;
                // A done arriving with a write defers RUN by one cycle so the write lands first
                if ((done_ev_r | done_pend_r) & wr_s) begin
                    done_pend_s = 1'b1;
                end else if (done_ev_r | done_pend_r) begin
                    state_next_s = ST_RUN;
                    run_entry_s  = 1'b1;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (done_ev_r) begin
                    state_next_s = ST_IDLE;
                end else if (tm_clear_r) begin
                    state_next_s = ST_RUN;
                end else if (tm.tm_halted) begin
                    state_next_s = ST_HALT;
                end else if (tm_step_s && (step_count_r == STEP_W'(MAX_STEPS - 1))) begin
                    state_next_s = ST_TIMEOUT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_HALT, ST_TIMEOUT: begin
                if (done_ev_r) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Tape pointer, write strobe, step counter and registered status outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tm_clear_r     <= 1'b0;
            tm_wr_en_r     <= 1'b0;
            tm_wr_addr_r   <= {ADDR_W{1'b0}};
            tm_wr_data_r   <= {DATA_W{1'b0}};
            addr_r         <= {ADDR_W{1'b0}};
            full_r         <= 1'b0;
            wr_pend_r      <= 1'b0;
            done_pend_r    <= 1'b0;
            step_count_r   <= {STEP_W{1'b0}};
            busy_r         <= 1'b0;
            compute_done_r <= 1'b0;
            timeout_r      <= 1'b0;
        end else begin
            tm_clear_r  <= clear_s;
            tm_wr_en_r  <= wr_s;
            wr_pend_r   <= pend_s;
            done_pend_r <= done_pend_s;
            if (capture_s) begin
                tm_wr_data_r <= data_s2_r;
            end
            // The pointer saturates on the last cell rather than wrapping
            if (pend_s) begin
                addr_r <= {ADDR_W{1'b0}};
                full_r <= 1'b0;
            end else if (wr_s) begin
                tm_wr_addr_r <= addr_r;
                if (addr_r == ADDR_W'(TAPE_LEN - 1)) begin
                    full_r <= 1'b1;
                end else begin
                    addr_r <= addr_r + ADDR_W'(1);
                end
            end
            if (run_entry_s) begin
                step_count_r <= {STEP_W{1'b0}};
            end else if (tm_step_s) begin
                step_count_r <= step_count_r + STEP_W'(1);
            end
            busy_r         <= (state_next_s == ST_LOAD) | (state_next_s == ST_RUN);
            compute_done_r <= (state_next_s == ST_HALT);
            timeout_r      <= (state_next_s == ST_TIMEOUT);
        end
    end

    assign tm.tm_clear    = tm_clear_r;
    assign tm.tm_wr_en    = tm_wr_en_r;
    assign tm.tm_wr_addr  = tm_wr_addr_r;
    assign tm.tm_wr_data  = tm_wr_data_r;
    assign tm.tm_step     = tm_step_s;
    assign busy           = busy_r;
    assign compute_done   = compute_done_r;
    assign timeout        = timeout_r;
    assign step_count     = step_count_r;

endmodule

// File: tb/tb_tm_sequencer.sv
// tb_tm_sequencer: self-checking bench for tm_sequencer with a tape-write scoreboard
// and a behavioural core that raises tm_halted after a programmable number of steps.
module tb_tm_sequencer;

    localparam int DATA_W = 4;
    localparam int ADDR_W = 6;
    localparam int STEP_W = 10;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int halt_after;
        int exp_count;
        int exp_done;
        int exp_tmo;
    } run_vec_t;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [DATA_W-1:0] data_in = 4'h0;
    logic              next_in = 1'b0;
    logic              done_in = 1'b0;
    logic              busy;
    logic              compute_done;
    logic              timeout;
    logic [STEP_W-1:0] step_count;

    tm_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) tm_if ();

    tm_sequencer #(.DATA_W(DATA_W), .TAPE_LEN(64), .MAX_STEPS(1000)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .data_in      (data_in),
        .next_in      (next_in),
        .done_in      (done_in),
        .tm           (tm_if),
        .busy         (busy),
        .compute_done (compute_done),
        .timeout      (timeout),
        .step_count   (step_count)
    );

    always #5 clock = ~clock;

    // Core model: counts steps since the last clear and reports halt at the programmed count
    int core_steps;
    int halt_limit = 2000;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) core_steps <= 0;
        else if (tm_if.tm_clear) core_steps <= 0;
        else if (tm_if.tm_step) core_steps <= core_steps + 1;
    end
    assign tm_if.tm_halted = (core_steps >= halt_limit);

    int  n_checks = 0;
    int  n_fail = 0;
    int  step_pulses = 0;
    int  clear_pulses = 0;
    int  wr_pulses = 0;
    int  viol = 0;
    wr_t exp_q[$];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One clock cycle; samples strobes at the falling edge and scores tape writes
    task automatic tick();
        wr_t e;
        @(negedge clock);
        if (tm_if.tm_step) step_pulses++;
        if (tm_if.tm_clear) clear_pulses++;
        if ((int'(tm_if.tm_step) + int'(tm_if.tm_clear) + int'(tm_if.tm_wr_en)) > 1) viol++;
        if (tm_if.tm_step && tm_if.tm_halted) viol++;
        if (tm_if.tm_wr_en) begin
            wr_pulses++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wr_unexpected: write addr=%0d data=%0d, none expected",
                         tm_if.tm_wr_addr, tm_if.tm_wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", int'(tm_if.tm_wr_addr), e.addr);
                check("wr_data", int'(tm_if.tm_wr_data), e.data);
            end
        end
    endtask

    task automatic press(input logic nxt, input logic dn, input logic [DATA_W-1:0] d);
        data_in = d;
        next_in = nxt;
        done_in = dn;
        repeat (4) tick();
        next_in = 1'b0;
        done_in = 1'b0;
        repeat (4) tick();
    endtask

    task automatic push_wr(input int a, input int d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (!(compute_done || timeout) && n < budget) begin
            tick();
            n++;
        end
        check("run_end_within_budget", int'(compute_done || timeout), 1);
    endtask

    initial begin
        run_vec_t tbl[4];
        int base_steps;
        int base_wr;
        int base_clear;
        logic [DATA_W-1:0] d;

        tbl[0] = '{halt_after: 5,  exp_count: 5,  exp_done: 1, exp_tmo: 0};
        tbl[1] = '{halt_after: 0,  exp_count: 0,  exp_done: 1, exp_tmo: 0};
        tbl[2] = '{halt_after: 1,  exp_count: 1,  exp_done: 1, exp_tmo: 0};
        tbl[3] = '{halt_after: 37, exp_count: 37, exp_done: 1, exp_tmo: 0};

        // Reset state
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_compute_done", int'(compute_done), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_step_count", int'(step_count), 0);
        check("rst_tm_clear", int'(tm_if.tm_clear), 0);
        check("rst_tm_wr_en", int'(tm_if.tm_wr_en), 0);
        check("rst_tm_wr_addr", int'(tm_if.tm_wr_addr), 0);
        check("rst_tm_step", int'(tm_if.tm_step), 0);
        reset_n = 1'b1;
        repeat (4) tick();

        // Load 0xA, 0x3, then start
        halt_limit = 2000;
        push_wr(0, 10);
        press(1'b1, 1'b0, 4'hA);
        push_wr(1, 3);
        press(1'b1, 1'b0, 4'h3);
        check("load_clear_pulses", clear_pulses, 1);
        check("load_wr_pulses", wr_pulses, 2);
        check("load_queue_empty", exp_q.size(), 0);
        check("load_busy", int'(busy), 1);
        base_steps = step_pulses;
        base_wr = wr_pulses;
        press(1'b0, 1'b1, 4'h0);
        check("run_busy", int'(busy), 1);
        check("run_compute_done", int'(compute_done), 0);

`ifndef TM_SEQ_SINGLE_STEP_EN
        // Free run to the step budget
        wait_end(1200);
        check("tmo_timeout", int'(timeout), 1);
        check("tmo_compute_done", int'(compute_done), 0);
        check("tmo_step_count", int'(step_count), 1000);
        check("tmo_step_pulses", step_pulses - base_steps, 1000);
        check("tmo_busy", int'(busy), 0);
        repeat (5) tick();
        check("tmo_no_more_steps", step_pulses - base_steps, 1000);
        press(1'b0, 1'b1, 4'h0);
        check("tmo_ack_timeout", int'(timeout), 0);
        check("tmo_ack_busy", int'(busy), 0);

        // Table of halt points, each run started from IDLE on an empty tape
        for (int i = 0; i < 4; i++) begin
            halt_limit = tbl[i].halt_after;
            base_steps = step_pulses;
            base_clear = clear_pulses;
            press(1'b0, 1'b1, 4'h0);
            wait_end(1200);
            check("tbl_step_count", int'(step_count), tbl[i].exp_count);
            check("tbl_step_pulses", step_pulses - base_steps, tbl[i].exp_count);
            check("tbl_compute_done", int'(compute_done), tbl[i].exp_done);
            check("tbl_timeout", int'(timeout), tbl[i].exp_tmo);
            check("tbl_clear_once", clear_pulses - base_clear, 1);
            press(1'b0, 1'b1, 4'h0);
            check("tbl_ack_idle", int'(compute_done || timeout || busy), 0);
        end
`else
        // Single-step: only next presses advance the core
        check("ss_no_free_steps", step_pulses - base_steps, 0);
        for (int i = 0; i < 3; i++) begin
            press(1'b1, 1'b0, 4'h0);
        end
        check("ss_step_pulses", step_pulses - base_steps, 3);
        check("ss_step_count", int'(step_count), 3);
        check("ss_busy", int'(busy), 1);
        check("ss_no_writes", wr_pulses - base_wr, 0);
        press(1'b0, 1'b1, 4'h0);
        check("ss_abort_busy", int'(busy), 0);
        check("ss_abort_holds_count", int'(step_count), 3);
`endif

        // Tape full: 65 presses give 64 writes and no wrap
        halt_limit = 2000;
        base_wr = wr_pulses;
        base_clear = clear_pulses;
        for (int i = 0; i < 65; i++) begin
            d = 4'((i * 7) % 16);
            if (i < 64) push_wr(i, (i * 7) % 16);
            press(1'b1, 1'b0, d);
        end
        check("full_wr_pulses", wr_pulses - base_wr, 64);
        check("full_queue_empty", exp_q.size(), 0);
        check("full_last_addr", int'(tm_if.tm_wr_addr), 63);
        check("full_clear_once", clear_pulses - base_clear, 1);
        check("full_busy", int'(busy), 1);
        halt_limit = 0;
        press(1'b0, 1'b1, 4'h0);
        wait_end(50);
        check("full_halt_done", int'(compute_done), 1);
        check("full_halt_count", int'(step_count), 0);
        press(1'b0, 1'b1, 4'h0);
        check("full_ack_idle", int'(busy || compute_done), 0);

        // next and done together in LOAD: write lands, then RUN (core halts at once)
        base_wr = wr_pulses;
        push_wr(0, 5);
        press(1'b1, 1'b0, 4'h5);
        push_wr(1, 6);
        press(1'b1, 1'b1, 4'h6);
        wait_end(50);
        check("both_wr_pulses", wr_pulses - base_wr, 2);
        check("both_queue_empty", exp_q.size(), 0);
        check("both_compute_done", int'(compute_done), 1);
        check("both_step_count", int'(step_count), 0);
        press(1'b0, 1'b1, 4'h0);

        // Reset mid-RUN with done held across release
        halt_limit = 2000;
        press(1'b0, 1'b1, 4'h0);
        check("mid_run_busy", int'(busy), 1);
        done_in = 1'b1;
        reset_n = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_step_count", int'(step_count), 0);
        check("arst_tm_step", int'(tm_if.tm_step), 0);
        check("arst_strobes", int'(tm_if.tm_clear || tm_if.tm_wr_en), 0);
        check("arst_status", int'(compute_done || timeout), 0);
        repeat (2) tick();
        reset_n = 1'b1;
        base_clear = clear_pulses;
        repeat (10) tick();
        check("held_pin_no_event_busy", int'(busy), 0);
        check("held_pin_no_clear", clear_pulses - base_clear, 0);
        done_in = 1'b0;
        repeat (4) tick();
        press(1'b0, 1'b1, 4'h0);
        check("post_release_event", int'(busy), 1);
        press(1'b0, 1'b1, 4'h0);
        check("post_release_abort", int'(busy), 0);

        check("strobe_exclusive", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
